// File: rtl/top_6502_system.sv
// Minimal 6502-compatible system: multicycle core running the load/store/logic subset
// out of on-chip ROM ($F000-$FFFF), with 2 KiB of RAM at $0000.

module Mem6502 #(
  parameter int RAM_AW = 11,
  parameter int ROM_AW = 12
) (
  input  logic        clk_i,
  input  logic [15:0] addr_i,
  input  logic        we_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o
);
  logic [7:0] RAM [0:(1<<RAM_AW)-1];
  logic [7:0] ROM [0:(1<<ROM_AW)-1];
  logic       ramSel;
  logic       romSel;

  assign ramSel = (addr_i[15:RAM_AW] == '0);
  assign romSel = (addr_i[15:ROM_AW] == '1);

  always_comb begin
    rdata_o = 8'hFF;
    if (ramSel)      rdata_o = RAM[addr_i[RAM_AW-1:0]];
    else if (romSel) rdata_o = ROM[addr_i[ROM_AW-1:0]];
  end

  // ROM and unmapped writes are dropped; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i && ramSel) RAM[addr_i[RAM_AW-1:0]] <= wdata_i;
  end
endmodule

module top_6502_system #(
  parameter int RAM_AW = 11,
  parameter int ROM_AW = 12
) (
  input logic ph1,
  input logic ph2,
  input logic reset
);
  typedef enum logic [3:0] {
    VEC_LO, VEC_HI, FETCH, OP1, OP2, ADDR_LO, ADDR_HI, PTR_LO, PTR_HI, EXEC, WRITE
  } state_e;
  typedef enum logic [3:0] {
    M_IMP, M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABSX, M_ABSY, M_INDX, M_INDY, M_JMP
  } mode_e;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_AND, OP_ORA, OP_EOR, OP_STA, OP_LDX, OP_LDY, OP_STX, OP_STY, OP_JMP
  } op_e;
  typedef struct packed {
    op_e   op;
    mode_e mode;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] opc);
    dec_t d;
    d.op   = OP_NOP;
    d.mode = M_IMP;
    if (opc[1:0] == 2'b01) begin
      case (opc[7:5])
        3'd0:    d.op = OP_ORA;
        3'd1:    d.op = OP_AND;
        3'd2:    d.op = OP_EOR;
        3'd4:    d.op = OP_STA;
        3'd5:    d.op = OP_LDA;
        default: d.op = OP_NOP;
      endcase
      case (opc[4:2])
        3'd0:    d.mode = M_INDX;
        3'd1:    d.mode = M_ZP;
        3'd2:    d.mode = M_IMM;
        3'd3:    d.mode = M_ABS;
        3'd4:    d.mode = M_INDY;
        3'd5:    d.mode = M_ZPX;
        3'd6:    d.mode = M_ABSY;
        default: d.mode = M_ABSX;
      endcase
      // ADC/CMP/SBC and the STA-immediate hole all degrade to a 1-byte NOP.
      if (d.op == OP_NOP || (d.op == OP_STA && d.mode == M_IMM)) begin
        d.op   = OP_NOP;
        d.mode = M_IMP;
      end
    end else begin
      case (opc)
        8'hA2:   d = '{OP_LDX, M_IMM};
        8'hA6:   d = '{OP_LDX, M_ZP};
        8'hB6:   d = '{OP_LDX, M_ZPY};
        8'hAE:   d = '{OP_LDX, M_ABS};
        8'hBE:   d = '{OP_LDX, M_ABSY};
        8'hA0:   d = '{OP_LDY, M_IMM};
        8'hA4:   d = '{OP_LDY, M_ZP};
        8'hB4:   d = '{OP_LDY, M_ZPX};
        8'hAC:   d = '{OP_LDY, M_ABS};
        8'hBC:   d = '{OP_LDY, M_ABSX};
        8'h86:   d = '{OP_STX, M_ZP};
        8'h96:   d = '{OP_STX, M_ZPY};
        8'h8E:   d = '{OP_STX, M_ABS};
        8'h84:   d = '{OP_STY, M_ZP};
        8'h94:   d = '{OP_STY, M_ZPX};
        8'h8C:   d = '{OP_STY, M_ABS};
        8'h4C:   d = '{OP_JMP, M_JMP};
        default: ;
      endcase
    end
    return d;
  endfunction

  state_e      state_q, state_d;
  dec_t        dec_q, dec_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ea_q, ea_d;
  logic [7:0]  ptrLo_q, ptrLo_d;
  logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d;
  logic        n_q, n_d, z_q, z_d;

  logic [15:0] busAddr;
  logic        busWe;
  logic [7:0]  busWdata;
  logic [7:0]  busRdata;
  dec_t        fetchDec;
  logic        isStore;
  logic        writesReg;
  logic        useY;
  logic [7:0]  idx;
  logic [15:0] idxOff;
  logic [7:0]  zpSum;
  logic [7:0]  ptrNext;
  state_e      memState;
  logic        execEn;
  logic [7:0]  result;
  logic        unused_ph2;

  assign unused_ph2 = ph2;
  assign fetchDec   = decode(busRdata);
  assign isStore    = dec_q.op inside {OP_STA, OP_STX, OP_STY};
  assign writesReg  = dec_q.op inside {OP_LDA, OP_AND, OP_ORA, OP_EOR, OP_LDX, OP_LDY};
  assign useY       = dec_q.mode inside {M_ZPY, M_ABSY, M_INDY};
  assign idx        = useY ? y_q : x_q;
  assign idxOff     = (dec_q.mode inside {M_ABSX, M_ABSY, M_INDY}) ? {8'h00, idx} : 16'h0000;
  assign zpSum      = ea_q[7:0] + idx;
  assign ptrNext    = ea_q[7:0] + 8'h01;
  assign memState   = isStore ? WRITE : EXEC;

  Mem6502 #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW)) mem (
    .clk_i   (ph1),
    .addr_i  (busAddr),
    .we_i    (busWe),
    .wdata_i (busWdata),
    .rdata_o (busRdata)
  );

  // Bus address depends only on registered state, keeping memory reads loop-free.
  always_comb begin
    busAddr = ea_q;
    busWe   = 1'b0;
    case (state_q)
      VEC_LO:          busAddr = 16'hFFFC;
      VEC_HI:          busAddr = 16'hFFFD;
      FETCH, OP1, OP2: busAddr = pc_q;
      PTR_LO:          busAddr = {8'h00, ea_q[7:0]};
      PTR_HI:          busAddr = {8'h00, ptrNext};
      WRITE:           busWe   = 1'b1;
      default:         ;
    endcase
  end

  always_comb begin
    case (dec_q.op)
      OP_STX:  busWdata = x_q;
      OP_STY:  busWdata = y_q;
      default: busWdata = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    ea_d    = ea_q;
    ptrLo_d = ptrLo_q;
    execEn  = 1'b0;
    case (state_q)
      VEC_LO: begin
        pc_d    = {pc_q[15:8], busRdata};
        state_d = VEC_HI;
      end
      VEC_HI: begin
        pc_d    = {busRdata, pc_q[7:0]};
        state_d = FETCH;
      end
      FETCH: begin
        dec_d   = fetchDec;
        pc_d    = pc_q + 16'd1;
        state_d = (fetchDec.mode == M_IMP) ? EXEC : OP1;
      end
      OP1: begin
        pc_d = pc_q + 16'd1;
        ea_d = {8'h00, busRdata};
        case (dec_q.mode)
          M_IMM: begin
            execEn  = 1'b1;
            state_d = FETCH;
          end
          M_ZP:                 state_d = memState;
          M_ZPX, M_ZPY, M_INDX: state_d = ADDR_LO;
          M_INDY:               state_d = PTR_LO;
          default:              state_d = OP2;
        endcase
      end
      OP2: begin
        if (dec_q.mode == M_JMP) begin
          pc_d    = {busRdata, ea_q[7:0]};
          state_d = FETCH;
        end else begin
          pc_d    = pc_q + 16'd1;
          ea_d    = {busRdata, ea_q[7:0]} + idxOff;
          state_d = memState;
        end
      end
      ADDR_LO: begin
        ea_d    = {8'h00, zpSum};
        state_d = (dec_q.mode == M_INDX) ? PTR_LO : memState;
      end
      PTR_LO: begin
        ptrLo_d = busRdata;
        state_d = PTR_HI;
      end
      PTR_HI: begin
        ea_d    = {busRdata, ptrLo_q} + idxOff;
        state_d = memState;
      end
      EXEC: begin
        execEn  = (dec_q.mode != M_IMP);
        state_d = FETCH;
      end
      WRITE:   state_d = FETCH;
      default: state_d = VEC_LO;
    endcase
  end

  always_comb begin
    a_d = a_q;
    x_d = x_q;
    y_d = y_q;
    n_d = n_q;
    z_d = z_q;
    case (dec_q.op)
      OP_AND:  result = a_q & busRdata;
      OP_ORA:  result = a_q | busRdata;
      OP_EOR:  result = a_q ^ busRdata;
      default: result = busRdata;
    endcase
    if (execEn && writesReg) begin
      n_d = result[7];
      z_d = (result == 8'h00);
      case (dec_q.op)
        OP_LDX:  x_d = result;
        OP_LDY:  y_d = result;
        default: a_d = result;
      endcase
    end
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= VEC_LO;
      dec_q   <= '{OP_NOP, M_IMP};
      pc_q    <= 16'h0000;
      ea_q    <= 16'h0000;
      ptrLo_q <= 8'h00;
      a_q     <= 8'h00;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
      ea_q    <= ea_d;
      ptrLo_q <= ptrLo_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end
endmodule

// File: tb/tb_top_6502_system.sv
// Directed bench for top_6502_system: runs small hand-assembled programs from ROM
// and compares registers and RAM against hand-computed results.

module tb_top_6502_system;
  logic       ph1 = 1'b0;
  logic       ph2;
  logic       reset = 1'b1;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] prog[$];

  always #10 ph1 = ~ph1;
  assign ph2 = ~ph1;

  top_6502_system dut (
    .ph1   (ph1),
    .ph2   (ph2),
    .reset (reset)
  );

  task automatic loadRom();
    for (int i = 0; i < prog.size(); i++) dut.mem.ROM[i] = prog[i];
    dut.mem.ROM[12'hFFC] = 8'h00;
    dut.mem.ROM[12'hFFD] = 8'hF0;
  endtask

  // Holds reset across a program load; returns on the falling edge where reset drops.
  task automatic applyStimulus();
    @(negedge ph1);
    reset = 1'b1;
    loadRom();
    repeat (2) @(negedge ph1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    prog = '{8'hA9, 8'hFF, 8'h29, 8'h0F, 8'h09, 8'hA0, 8'h49, 8'h05,
             8'h85, 8'hA9, 8'h4C, 8'h0A, 8'hF0};
    loadRom();
    #50;
    checks++; if (dut.a_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_a got %h expected 00", dut.a_q); end
    checks++; if (dut.x_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_x got %h expected 00", dut.x_q); end
    checks++; if (dut.y_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_y got %h expected 00", dut.y_q); end
    checks++; if ({dut.n_q, dut.z_q} !== 2'b00) begin errors++; $display("[TB] FAIL reset_nz got %b expected 00", {dut.n_q, dut.z_q}); end
    checks++; if (dut.pc_q !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc got %h expected 0000", dut.pc_q); end
    #50;
    reset = 1'b0;
    #21;
    checks++; if (dut.pc_q !== 16'h0000) begin errors++; $display("[TB] FAIL vec_lo_pc got %h expected 0000", dut.pc_q); end
    #20;
    checks++; if (dut.pc_q !== 16'hF000) begin errors++; $display("[TB] FAIL vec_hi_pc got %h expected f000", dut.pc_q); end
    #20;
    checks++; if (dut.pc_q !== 16'hF001) begin errors++; $display("[TB] FAIL first_fetch_pc got %h expected f001", dut.pc_q); end
  endtask

  task automatic test_logic_chain();
    // Edge 13 after release ends STA $A9; sampled on the following falling edge.
    repeat (10) @(negedge ph1);
    checks++; if (dut.mem.RAM[169] !== 8'hAA) begin errors++; $display("[TB] FAIL chain_ram got %h expected aa", dut.mem.RAM[169]); end
    checks++; if (dut.a_q !== 8'hAA) begin errors++; $display("[TB] FAIL chain_a got %h expected aa", dut.a_q); end
    checks++; if (dut.n_q !== 1'b1) begin errors++; $display("[TB] FAIL chain_n got %b expected 1", dut.n_q); end
    checks++; if (dut.z_q !== 1'b0) begin errors++; $display("[TB] FAIL chain_z got %b expected 0", dut.z_q); end
    checks++; if (dut.pc_q !== 16'hF00A) begin errors++; $display("[TB] FAIL chain_pc got %h expected f00a", dut.pc_q); end
  endtask

  task automatic test_regression();
    bit found = 1'b0;
    prog = '{8'hA9, 8'h00, 8'h85, 8'hA9,                 // clear RAM[$A9]
             8'hA9, 8'h40, 8'h85, 8'h32, 8'hA9, 8'h02, 8'h85, 8'h33,
             8'hA9, 8'h55, 8'h8D, 8'h40, 8'h02,
             8'hA2, 8'h02, 8'hA9, 8'hFF, 8'h41, 8'h30, 8'h85, 8'h50,   // EOR ($30,X)
             8'hA9, 8'h00, 8'h85, 8'h60, 8'hA9, 8'h02, 8'h85, 8'h61,
             8'hA9, 8'h3C, 8'h8D, 8'h10, 8'h02,
             8'hA0, 8'h10, 8'hB1, 8'h60, 8'h85, 8'h51,                 // LDA ($60),Y
             8'hBD, 8'hFF, 8'hF0, 8'h85, 8'h52,                        // LDA $F0FF,X
             8'hA2, 8'h20, 8'hA9, 8'h5A, 8'h85, 8'h10, 8'hA9, 8'h00,
             8'hB5, 8'hF0, 8'h85, 8'h53,                               // LDA $F0,X wraps
             8'h96, 8'hF0, 8'h8C, 8'h54, 8'h00,                        // STX $F0,Y ; STY $0054
             8'hA0, 8'h00, 8'hA2, 8'h03, 8'hB5, 8'h4D,
             8'h99, 8'hA9, 8'h00, 8'h4C, 8'h4B, 8'hF0};
    dut.mem.ROM[12'h101] = 8'hC3;
    applyStimulus();
    repeat (10) @(negedge ph1);
    for (int i = 0; i < 290 && !found; i++) begin
      @(negedge ph1);
      if (dut.mem.RAM[169] == 8'hAA) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL regression_done RAM[169] got %h expected aa before 6000 ns", dut.mem.RAM[169]); end
    repeat (5) @(negedge ph1);
    checks++; if (dut.mem.RAM[12'h032] !== 8'h40) begin errors++; $display("[TB] FAIL ram_32 got %h expected 40", dut.mem.RAM[12'h032]); end
    checks++; if (dut.mem.RAM[12'h240] !== 8'h55) begin errors++; $display("[TB] FAIL ram_240 got %h expected 55", dut.mem.RAM[12'h240]); end
    checks++; if (dut.mem.RAM[12'h050] !== 8'hAA) begin errors++; $display("[TB] FAIL indx_eor got %h expected aa", dut.mem.RAM[12'h050]); end
    checks++; if (dut.mem.RAM[12'h051] !== 8'h3C) begin errors++; $display("[TB] FAIL indy_lda got %h expected 3c", dut.mem.RAM[12'h051]); end
    checks++; if (dut.mem.RAM[12'h052] !== 8'hC3) begin errors++; $display("[TB] FAIL absx_lda got %h expected c3", dut.mem.RAM[12'h052]); end
    checks++; if (dut.mem.RAM[12'h053] !== 8'h5A) begin errors++; $display("[TB] FAIL zpx_wrap got %h expected 5a", dut.mem.RAM[12'h053]); end
    checks++; if (dut.mem.RAM[12'h000] !== 8'h20) begin errors++; $display("[TB] FAIL stx_zpy_wrap got %h expected 20", dut.mem.RAM[12'h000]); end
    checks++; if (dut.mem.RAM[12'h054] !== 8'h10) begin errors++; $display("[TB] FAIL sty_abs got %h expected 10", dut.mem.RAM[12'h054]); end
    checks++; if (dut.a_q !== 8'hAA) begin errors++; $display("[TB] FAIL regr_a got %h expected aa", dut.a_q); end
    checks++; if (dut.x_q !== 8'h03) begin errors++; $display("[TB] FAIL regr_x got %h expected 03", dut.x_q); end
    checks++; if (dut.y_q !== 8'h00) begin errors++; $display("[TB] FAIL regr_y got %h expected 00", dut.y_q); end
    checks++; if ({dut.n_q, dut.z_q} !== 2'b10) begin errors++; $display("[TB] FAIL regr_nz got %b expected 10", {dut.n_q, dut.z_q}); end
  endtask

  task automatic test_back_to_back_reset();
    prog = '{8'hA9, 8'h00, 8'h85, 8'h70,                 // LDA #0 ; STA $70
             8'hAD, 8'h00, 8'h40, 8'h85, 8'h71,          // LDA $4000 (unmapped) ; STA $71
             8'hA9, 8'h00, 8'h85, 8'h72,
             8'hA2, 8'h07, 8'hA0, 8'h09, 8'hA9, 8'h77,
             8'h8D, 8'h72, 8'h00, 8'h4C, 8'h16, 8'hF0};   // STA $0072 ; JMP self
    applyStimulus();
    // Falling edge after edge 28: STA abs is in its write cycle.
    repeat (28) @(negedge ph1);
    checks++; if (dut.a_q !== 8'h77) begin errors++; $display("[TB] FAIL pre_abort_a got %h expected 77", dut.a_q); end
    checks++; if (dut.x_q !== 8'h07) begin errors++; $display("[TB] FAIL pre_abort_x got %h expected 07", dut.x_q); end
    checks++; if (dut.y_q !== 8'h09) begin errors++; $display("[TB] FAIL pre_abort_y got %h expected 09", dut.y_q); end
    checks++; if (dut.mem.RAM[12'h071] !== 8'hFF) begin errors++; $display("[TB] FAIL unmapped_read got %h expected ff", dut.mem.RAM[12'h071]); end
    checks++; if (dut.mem.RAM[12'h072] !== 8'h00) begin errors++; $display("[TB] FAIL pre_abort_ram got %h expected 00", dut.mem.RAM[12'h072]); end
    reset = 1'b1;
    #1;
    checks++; if ({dut.a_q, dut.x_q, dut.y_q} !== 24'h0) begin errors++; $display("[TB] FAIL abort_regs got %h expected 000000", {dut.a_q, dut.x_q, dut.y_q}); end
    checks++; if (dut.pc_q !== 16'h0000) begin errors++; $display("[TB] FAIL abort_pc got %h expected 0000", dut.pc_q); end
    repeat (3) @(negedge ph1);
    checks++; if (dut.mem.RAM[12'h072] !== 8'h00) begin errors++; $display("[TB] FAIL abort_write_dropped got %h expected 00", dut.mem.RAM[12'h072]); end
    reset = 1'b0;
    repeat (4) @(negedge ph1);
    checks++; if (dut.pc_q !== 16'hF002) begin errors++; $display("[TB] FAIL restart_pc got %h expected f002", dut.pc_q); end
    checks++; if ({dut.n_q, dut.z_q} !== 2'b01) begin errors++; $display("[TB] FAIL restart_zero_flag got %b expected 01", {dut.n_q, dut.z_q}); end
    repeat (30) @(negedge ph1);
    checks++; if (dut.mem.RAM[12'h072] !== 8'h77) begin errors++; $display("[TB] FAIL rerun_store got %h expected 77", dut.mem.RAM[12'h072]); end
    checks++; if ({dut.n_q, dut.z_q} !== 2'b00) begin errors++; $display("[TB] FAIL rerun_nz got %b expected 00", {dut.n_q, dut.z_q}); end
  endtask

  initial begin
    test_reset();
    test_logic_chain();
    test_regression();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
